// File: rtl/saturn_mouse_port_pkg.sv
// Shared types and constants for the Saturn peripheral-port responders.
package saturn_periph_pkg;

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} port_state_t;

    localparam logic [3:0] MOUSE_ID0 = 4'h0;
    localparam logic [3:0] MOUSE_ID1 = 4'hB;
    localparam logic [3:0] MOUSE_ID2 = 4'hF;
    localparam logic [3:0] MOUSE_ID3 = 4'hF;

    localparam int unsigned NIB_COUNT = 10;

    typedef struct packed {
        logic [3:0] flags;
        logic [3:0] buttons;
        logic [7:0] x;
        logic [7:0] y;
    } mouse_snap_t;

    // Index NIB_COUNT and beyond reads as zero once the report is exhausted.
    function automatic logic [3:0] mouse_nibble(input mouse_snap_t s, input logic [3:0] idx);
        logic [3:0] nib;
        case (idx)
            4'd0:    nib = MOUSE_ID0;
            4'd1:    nib = MOUSE_ID1;
            4'd2:    nib = MOUSE_ID2;
            4'd3:    nib = MOUSE_ID3;
            4'd4:    nib = s.flags;
            4'd5:    nib = s.buttons;
            4'd6:    nib = s.x[7:4];
            4'd7:    nib = s.x[3:0];
            4'd8:    nib = s.y[7:4];
            4'd9:    nib = s.y[3:0];
            default: nib = 4'h0;
        endcase
        return nib;
    endfunction

endpackage

// File: rtl/saturn_mouse_port_if.sv
// Saturn controller-port handshake: host drives TH/TR, the peripheral answers on D/TL.
interface saturn_mouse_port_if;
    logic       th;
    logic       tr;
    logic [3:0] d;
    logic       tl;

    modport master (output th, output tr, input d, input tl);
    modport slave  (input th, input tr, output d, output tl);
endinterface

// File: rtl/saturn_mouse_port_sync_edge.sv
// Multi-stage synchronizer with a registered previous value for edge detection.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            chain <= {SYNC_STAGES{RESET_VALUE}};
            prev  <= RESET_VALUE;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], async_in};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    // Both operands are flops, so the edge strobes are glitch-free one-cycle pulses.
    assign level = chain[SYNC_STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;
endmodule

// File: rtl/saturn_mouse_port.sv
// Saturn shuttle-mouse responder: serves a 10-nibble report snapshotted at TH fall.
module saturn_mouse_port
    import saturn_periph_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [15:0] TIMEOUT     = 16'd4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    saturn_mouse_port_if.slave   port,
    input  logic [3:0]           flags,
    input  logic [3:0]           buttons,
    input  logic [7:0]           x,
    input  logic [7:0]           y,
    output logic                 reset_acc
);
    logic th_level, th_rise, th_fall;
    logic tr_level, tr_rise, tr_fall, tr_edge;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_th_sync (
        .clk(clk), .reset_n(reset_n), .async_in(port.th),
        .level(th_level), .rise(th_rise), .fall(th_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_tr_sync (
        .clk(clk), .reset_n(reset_n), .async_in(port.tr),
        .level(tr_level), .rise(tr_rise), .fall(tr_fall)
    );

    assign tr_edge = tr_rise | tr_fall;

    port_state_t state, state_n;
    mouse_snap_t snap, snap_n;
    logic [3:0]  idx, idx_n;
    logic [3:0]  d_q, d_n;
    logic        tl_q, tl_n;
    logic        tl_pend, tl_pend_n;
    logic [15:0] cnt, cnt_n;
    logic        acc_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            snap      <= '0;
            idx       <= '0;
            d_q       <= '0;
            tl_q      <= 1'b1;
            tl_pend   <= 1'b0;
            cnt       <= '0;
            reset_acc <= 1'b0;
        end else begin
            state     <= state_n;
            snap      <= snap_n;
            idx       <= idx_n;
            d_q       <= d_n;
            tl_q      <= tl_n;
            tl_pend   <= tl_pend_n;
            cnt       <= cnt_n;
            reset_acc <= acc_n;
        end
    end

    always_comb begin
        state_n   = state;
        snap_n    = snap;
        idx_n     = idx;
        d_n       = d_q;
        tl_n      = tl_q;
        tl_pend_n = 1'b0;
        cnt_n     = cnt;
        acc_n     = 1'b0;

        // TL follows the D update by one cycle via the pending flag.
        if (tl_pend)
            tl_n = ~tl_q;

        if (th_rise) begin
            state_n = IDLE;
            idx_n   = '0;
            d_n     = '0;
            tl_n    = 1'b1;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    idx_n = '0;
                    d_n   = '0;
                    tl_n  = 1'b1;
                    cnt_n = '0;
                    if (th_fall) begin
                        snap_n  = '{flags: flags, buttons: buttons, x: x, y: y};
                        acc_n   = 1'b1;
                        d_n     = mouse_nibble(snap_n, 4'd0);
                        state_n = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (tr_edge) begin
                        idx_n     = (idx == 4'(NIB_COUNT)) ? idx : idx + 4'd1;
                        d_n       = mouse_nibble(snap, idx_n);
                        tl_pend_n = 1'b1;
                        cnt_n     = '0;
                    end else if (cnt == TIMEOUT - 16'd1) begin
                        state_n = DONE;
                        d_n     = '0;
                        tl_n    = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 16'd1;
                    end
                end
                DONE: begin
                    d_n   = '0;
                    tl_n  = 1'b1;
                    cnt_n = '0;
                    if (th_level)
                        state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign port.d  = d_q;
    assign port.tl = tl_q;
endmodule
